inst_fetch_unit: RTL and testbench

- Sequential instruction-fetch front end for the RV64I core.
- Owns the PC and instruction register, and runs a req/ack handshake with instruction memory.
- Presents the fetched instruction and its opcode to the control unit.
- Consumes pc_write_en, jal_en, jalr_en and branch_taken back from control/datapath to choose the next PC.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/fetch_timeout_counter.sv | 42 ++++
 rtl/inst_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared encodings for the RV64I instruction-fetch front end: FSM states,
// fault cause codes, the reset NOP and the default reset PC.
package inst_fetch_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_FETCH = 2'd1;
    localparam logic [1:0] STATE_ISSUE = 2'd2;
    localparam logic [1:0] STATE_FAULT = 2'd3;

    localparam logic [1:0] FAULT_NONE       = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT    = 2'b01;
    localparam logic [1:0] FAULT_MISALIGNED = 2'b10;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0040_0000;

    // Redirect targets must be 4-byte aligned.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive FETCH cycles without a memory ack; expired flags the
// last permitted wait cycle (count == TIMEOUT_CYCLES-1).
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == LIMIT);

    // Next count: saturates at the limit so it never wraps back past it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Sequential fetch front end: owns PC and instruction register, runs the
// imem req/ack handshake. Optional perf counters under INST_FETCH_COUNTERS_EN.
module inst_fetch_unit
    import inst_fetch_pkg::*;
#(
    parameter int               XLEN           = 64,
    parameter logic [XLEN-1:0]  RESET_PC       = DEFAULT_RESET_PC[XLEN-1:0],
    parameter int               TIMEOUT_CYCLES = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic [6:0]      inst_opcode,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    input  logic            pc_write_en,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] target_addr,
    output logic            fault,
    output logic [1:0]      fault_cause
`ifdef INST_FETCH_COUNTERS_EN
    ,
    output logic [63:0]     fetch_count,
    output logic [63:0]     wait_count
`endif
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [1:0]      cause_q, cause_d;
    logic            timeout_expired_s;
    logic            in_fetch_s;
    logic            redirect_s;

    assign in_fetch_s = (state_q == STATE_FETCH);
    assign redirect_s = jal_en | jalr_en | branch_taken;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_fetch_s || imem_ack),
        .enable  (in_fetch_s && !imem_ack),
        .expired (timeout_expired_s)
    );

    // Next-state, PC and instruction register logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cause_d = cause_q;
        case (state_q)
            STATE_IDLE: begin
                state_d = STATE_FETCH;
            end
            STATE_FETCH: begin
                // Ack takes priority over a coincident timeout.
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = STATE_ISSUE;
                end else if (timeout_expired_s) begin
                    state_d = STATE_FAULT;
                    cause_d = FAULT_TIMEOUT;
                end else begin
                    state_d = STATE_FETCH;
                end
            end
            STATE_ISSUE: begin
                if (!pc_write_en) begin
                    state_d = STATE_ISSUE;
                end else if (redirect_s) begin
                    if (is_word_aligned(target_addr[1:0])) begin
                        pc_d    = target_addr;
                        state_d = STATE_FETCH;
                    end else begin
                        state_d = STATE_FAULT;
                        cause_d = FAULT_MISALIGNED;
                    end
                end else begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = STATE_FETCH;
                end
            end
            STATE_FAULT: begin
                state_d = STATE_FAULT;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            cause_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cause_q <= cause_d;
        end
    end

    assign imem_req    = in_fetch_s;
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign inst_opcode = inst_q[6:0];
    assign inst_valid  = (state_q == STATE_ISSUE);
    assign pc          = pc_q;
    assign pc_plus_4   = pc_q + XLEN'(4);
    assign fault       = (state_q == STATE_FAULT);
    assign fault_cause = cause_q;

`ifdef INST_FETCH_COUNTERS_EN
    logic [63:0] fetch_count_q;
    logic [63:0] wait_count_q;

    // Completed fetches and ack-less wait cycles, both wrapping at 2^64.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= 64'd0;
            wait_count_q  <= 64'd0;
        end else begin
            if (in_fetch_s && imem_ack) begin
                fetch_count_q <= fetch_count_q + 64'd1;
            end else begin
                fetch_count_q <= fetch_count_q;
            end
            if (in_fetch_s && !imem_ack) begin
                wait_count_q <= wait_count_q + 64'd1;
            end else begin
                wait_count_q <= wait_count_q;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign wait_count  = wait_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a
// randomized fetch/stall/redirect sequence against a transaction-level PC model.
module tb_inst_fetch_unit;

    localparam logic [63:0] RST_PC  = 64'h0000_0000_0040_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [6:0]  inst_opcode;
    logic        inst_valid;
    logic [63:0] pc;
    logic [63:0] pc_plus_4;
    logic        pc_write_en = 1'b0;
    logic        jal_en = 1'b0;
    logic        jalr_en = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] target_addr = 64'h0;
    logic        fault;
    logic [1:0]  fault_cause;
`ifdef INST_FETCH_COUNTERS_EN
    logic [63:0] fetch_count;
    logic [63:0] wait_count;
`endif

    int pass_cnt = 0;
    int check_cnt = 0;

    inst_fetch_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_opcode  (inst_opcode),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .pc_write_en  (pc_write_en),
        .jal_en       (jal_en),
        .jalr_en      (jalr_en),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .fault        (fault),
        .fault_cause  (fault_cause)
`ifdef INST_FETCH_COUNTERS_EN
        ,
        .fetch_count  (fetch_count),
        .wait_count   (wait_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write_en  = 1'b0;
        jal_en       = 1'b0;
        jalr_en      = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
    endtask

    // Leaves the DUT in IDLE just after reset release (between edges).
    task automatic apply_reset();
        idle_inputs();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic fetch_word(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
    endtask

    // Reset, then complete one fetch so the DUT sits in ISSUE at RST_PC.
    task automatic reset_and_issue(input logic [31:0] word);
        apply_reset();
        tick();
        fetch_word(word);
    endtask

    task automatic step_seq();
        pc_write_en = 1'b1;
        tick();
        pc_write_en = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        check_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else pass_cnt++;
        check_cnt++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", pc, RST_PC); else pass_cnt++;
        check_cnt++; if (imem_addr !== RST_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); else pass_cnt++;
        check_cnt++; if (inst !== NOP) $display("FAIL reset_inst: got %h want %h", inst, NOP); else pass_cnt++;
        check_cnt++; if (inst_opcode !== 7'b0010011) $display("FAIL reset_opcode: got %b want 0010011", inst_opcode); else pass_cnt++;
        check_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", inst_valid); else pass_cnt++;
        check_cnt++; if ({fault, fault_cause} !== 3'b000) $display("FAIL reset_fault: got %b want 000", {fault, fault_cause}); else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_cnt++; if (imem_req !== 1'b0) $display("FAIL idle_bubble: got req %0b want 0", imem_req); else pass_cnt++;
        tick();
        check_cnt++; if ({imem_req, inst_valid} !== 2'b10) $display("FAIL first_fetch_req: got req/valid %b want 10", {imem_req, inst_valid}); else pass_cnt++;
        check_cnt++; if (imem_addr !== RST_PC) $display("FAIL first_fetch_addr: got %h want %h", imem_addr, RST_PC); else pass_cnt++;
        tick();
        imem_ack = 1'b0;
        check_cnt++; if (inst_valid !== 1'b1) $display("FAIL first_issue_valid: got %0b want 1", inst_valid); else pass_cnt++;
        check_cnt++; if (inst_opcode !== 7'b0010011) $display("FAIL first_issue_opcode: got %b want 0010011", inst_opcode); else pass_cnt++;
        check_cnt++; if (inst !== 32'h0050_0093) $display("FAIL first_issue_inst: got %h want 00500093", inst); else pass_cnt++;
    endtask

    task automatic test_sequential();
        step_seq();
        check_cnt++; if (pc !== 64'h40_0004) $display("FAIL seq_pc1: got %h want 400004", pc); else pass_cnt++;
        check_cnt++; if (imem_req !== 1'b1) $display("FAIL seq_req1: got %0b want 1", imem_req); else pass_cnt++;
        fetch_word($urandom);
        step_seq();
        check_cnt++; if (pc !== 64'h40_0008) $display("FAIL seq_pc2: got %h want 400008", pc); else pass_cnt++;
    endtask

    task automatic test_stall_redirect();
        logic [31:0] word;
        word = $urandom;
        reset_and_issue(word);
        for (int i = 0; i < 5; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = ~word;
            jal_en     = 1'($urandom);
            tick();
            check_cnt++; if ({inst_valid, pc, inst} !== {1'b1, RST_PC, word})
                $display("FAIL stall_%0d: got valid/pc/inst %0b %h %h want 1 %h %h", i, inst_valid, pc, inst, RST_PC, word); else pass_cnt++;
        end
        idle_inputs();
        pc_write_en = 1'b1;
        jalr_en     = 1'b1;
        target_addr = 64'h40_0100;
        tick();
        idle_inputs();
        check_cnt++; if ({imem_req, imem_addr} !== {1'b1, 64'h40_0100}) $display("FAIL jalr_redirect: got req/addr %0b %h want 1 400100", imem_req, imem_addr); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        fetch_word($urandom);
        pc_write_en  = 1'b1;
        branch_taken = 1'b1;
        target_addr  = 64'h40_0102;
        tick();
        idle_inputs();
        check_cnt++; if ({fault, fault_cause} !== 3'b110) $display("FAIL misalign_fault: got %b want 110", {fault, fault_cause}); else pass_cnt++;
        check_cnt++; if (pc !== 64'h40_0100) $display("FAIL misalign_pc: got %h want 400100", pc); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            imem_ack    = 1'b1;
            pc_write_en = 1'b1;
            jal_en      = 1'b1;
            target_addr = 64'h1000;
            tick();
            check_cnt++; if ({fault, imem_req, inst_valid, pc} !== {3'b100, 64'h40_0100})
                $display("FAIL fault_sticky_%0d: got f/req/v/pc %0b%0b%0b %h want 100 400100", i, fault, imem_req, inst_valid, pc); else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        reset_and_issue($urandom);
        pc_write_en = 1'b1;
        jal_en      = 1'b1;
        target_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        idle_inputs();
        fetch_word($urandom);
        check_cnt++; if (pc_plus_4 !== 64'h0) $display("FAIL wrap_pc_plus_4: got %h want 0", pc_plus_4); else pass_cnt++;
        step_seq();
        check_cnt++; if ({pc, imem_addr} !== 128'h0) $display("FAIL wrap_pc: got pc/addr %h %h want 0 0", pc, imem_addr); else pass_cnt++;
    endtask

    task automatic test_timeout();
        apply_reset();
        tick();
        repeat (TIMEOUT - 1) tick();
        check_cnt++; if ({fault, imem_req} !== 2'b01) $display("FAIL timeout_early: got fault/req %b want 01", {fault, imem_req}); else pass_cnt++;
        tick();
        check_cnt++; if ({fault, fault_cause, imem_req} !== 4'b1010) $display("FAIL timeout_fault: got f/cause/req %b want 1010", {fault, fault_cause, imem_req}); else pass_cnt++;
        check_cnt++; if (pc !== RST_PC) $display("FAIL timeout_pc: got %h want %h", pc, RST_PC); else pass_cnt++;
    endtask

    task automatic test_ack_on_last();
        logic [31:0] word;
        word = $urandom;
        apply_reset();
        tick();
        repeat (TIMEOUT - 1) tick();
        fetch_word(word);
        check_cnt++; if ({fault, inst_valid, inst} !== {2'b01, word}) $display("FAIL ack_last: got f/v/inst %0b%0b %h want 01 %h", fault, inst_valid, inst, word); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [63:0] m_pc;
        logic [31:0] word;
        int          kind;
        int          waits;
        word = $urandom;
        reset_and_issue(word);
        m_pc = RST_PC;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                jal_en       = 1'($urandom);
                jalr_en      = 1'($urandom);
                branch_taken = 1'($urandom);
                target_addr  = {$urandom, $urandom};
                tick();
                check_cnt++; if ({inst_valid, pc} !== {1'b1, m_pc}) $display("FAIL rnd_stall_%0d: got v/pc %0b %h want 1 %h", t, inst_valid, pc, m_pc); else pass_cnt++;
            end
            idle_inputs();
            kind = $urandom_range(0, 1);
            if (kind == 0) begin
                m_pc = m_pc + 64'd4;
            end else begin
                target_addr = {$urandom, $urandom} & ~64'h3;
                case ($urandom_range(0, 3))
                    0: jal_en = 1'b1;
                    1: jalr_en = 1'b1;
                    2: branch_taken = 1'b1;
                    default: begin jal_en = 1'b1; branch_taken = 1'b1; end
                endcase
                m_pc = target_addr;
            end
            pc_write_en = 1'b1;
            tick();
            idle_inputs();
            check_cnt++; if ({imem_req, imem_addr} !== {1'b1, m_pc}) $display("FAIL rnd_next_%0d: got req/addr %0b %h want 1 %h", t, imem_req, imem_addr, m_pc); else pass_cnt++;
            waits = $urandom_range(0, TIMEOUT - 2);
            for (int w = 0; w < waits; w++) begin
                pc_write_en = 1'($urandom);
                jal_en      = 1'($urandom);
                target_addr = {$urandom, $urandom};
                tick();
            end
            idle_inputs();
            word = $urandom;
            fetch_word(word);
            check_cnt++; if ({inst_valid, fault, pc, inst, inst_opcode} !== {2'b10, m_pc, word, word[6:0]})
                $display("FAIL rnd_issue_%0d: got v/f/pc/inst %0b%0b %h %h want 10 %h %h", t, inst_valid, fault, pc, inst, m_pc, word); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        fetch_word(32'hDEAD_BEEF);
        pc_write_en = 1'b1;
        jal_en      = 1'b1;
        target_addr = 64'h8000_0000_0000_1000;
        tick();
        idle_inputs();
        check_cnt++; if ({imem_req, pc} !== {1'b1, 64'h8000_0000_0000_1000}) $display("FAIL pre_async: got req/pc %0b %h want 1 8000000000001000", imem_req, pc); else pass_cnt++;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_cnt++; if (imem_req !== 1'b0) $display("FAIL async_req: got %0b want 0", imem_req); else pass_cnt++;
        check_cnt++; if ({pc, inst, fault, inst_valid} !== {RST_PC, NOP, 2'b00}) $display("FAIL async_state: got pc/inst/f/v %h %h %0b%0b want %h %h 00", pc, inst, fault, inst_valid, RST_PC, NOP); else pass_cnt++;
        #10;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_stall_redirect();
        test_misaligned();
        test_wrap();
        test_timeout();
        test_ack_on_last();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
